rle_expander: RTL
=================

RLE_EXPANDER -- requirements
Module: rle_expander

Interface
REQ-001 Parameter PAIRS, default 8: (count, value) pairs per input beat.
REQ-002 Parameter VAL_W, default 32: value width in bits; output lanes = 512/VAL_W = 16.
REQ-003 Parameter CNT_W, default 32: run-count width in bits; PAIRS*(VAL_W+CNT_W) SHALL equal 512.
REQ-004 aclk  in  1  sole clock; all logic rising-edge.
REQ-005 aresetn  in  1  synchronous, active-low reset.
REQ-006 s_axis_tdata  in  512  compressed beat; pair i = bits [64i+63:64i], value = low 32 bits, count = high 32 bits.
REQ-007 s_axis_tkeep  in  64  byte enables; pair i valid only if tkeep[8i+7:8i] is all ones.
REQ-008 s_axis_tlast  in  1  last beat of compressed frame.
REQ-009 s_axis_tvalid / s_axis_tready  in / out  1 / 1  input handshake.
REQ-010 m_axis_tdata  out  512  expanded beat; lane j = bits [32j+31:32j].
REQ-011 m_axis_tkeep  out  64  4 bits per filled lane, lanes filled from lane 0 upward.
REQ-012 m_axis_tlast / m_axis_tvalid / m_axis_tready  out / out / in  1 / 1 / 1  output framing and handshake.
REQ-013 frames_done  out  32  count of output beats sent with tlast; wraps 2^32-1 -> 0.

Function
REQ-014 FSM states: IDLE, EXPAND, EMIT.
REQ-015 IDLE: s_axis_tready=1; on s_tvalid&s_tready, capture tdata/tkeep/tlast, pair_idx=0, rem=count of pair 0, next state EXPAND.
REQ-016 s_axis_tready SHALL be 0 in EXPAND and EMIT; one input beat held at a time.
REQ-017 EXPAND, per cycle: n = min(rem, 16-fill); write value into lanes fill..fill+n-1; fill+=n; rem-=n.
REQ-018 When rem-n==0 or the current pair is invalid, advance pair_idx in the same cycle and load the next pair count into rem.
REQ-019 Zero-count or invalid pairs consume one EXPAND cycle each and write no lanes.
REQ-020 When fill reaches 16, next state EMIT with tlast=0.
REQ-021 After the last pair (idx PAIRS-1 or first invalid pair) of a non-tlast beat, with fill<16: next state IDLE; fill and lane contents are retained across beats.
REQ-022 After the last pair of a tlast beat: next state EMIT with tlast=1, tkeep per fill; if fill==0, the beat carries tkeep=0, tlast=1 (frame-boundary marker).
REQ-023 If fill reaches 16 in the same cycle the final pair of a tlast beat is exhausted, emit the full beat with tlast=0, then a separate tkeep=0, tlast=1 beat.
REQ-024 EMIT: m_axis_tvalid=1; tdata/tkeep/tlast stable until m_axis_tready; unused lanes drive 0.
REQ-025 On EMIT handshake: fill=0; increment frames_done if tlast; resume EXPAND if pairs or rem remain in the held beat, else IDLE.
REQ-026 Arithmetic: fill is 5 bits (0..16); rem is CNT_W bits, never underflows; counts up to 2^32-1 expand without truncation.
REQ-027 Latency: first output beat valid no earlier than 2 cycles after the accepting input handshake.

Reset
REQ-028 While aresetn=0 at a clock edge: state=IDLE, fill=0, rem=0, pair_idx=0, frames_done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, s_axis_tready=0.
REQ-029 s_axis_tready SHALL rise to 1 the first cycle after aresetn returns high.
REQ-030 Reset mid-frame discards the held input beat and partial lanes; no output beat is emitted for them.

Verification
REQ-031 One tlast beat, pair0=(count 3, value 0xA), rest tkeep=0 -> one output: lanes 0-2 = 0xA, tkeep=0x0000_0FFF, tlast=1; frames_done=1.
REQ-032 One tlast beat, pair0=(20, 0x5) -> beat 1: 16 lanes 0x5, tkeep all ones, tlast=0; beat 2: lanes 0-3 0x5, tkeep=0xFFFF, tlast=1.
REQ-033 One tlast beat, pair0=(16, 0x7) -> full beat tlast=0, then tkeep=0, tlast=1 beat.
REQ-034 Beat A (no tlast) pair0=(10, 0x1); beat B (tlast) pair0=(0, 0x9), pair1=(6, 0x2) -> one beat: lanes 0-9 0x1, lanes 10-15 0x2, tlast=0; then tkeep=0, tlast=1 beat.
REQ-035 m_axis_tready held 0 for 5 cycles in EMIT -> tdata/tkeep/tlast unchanged; s_axis_tready stays 0.
REQ-036 aresetn low for 1 cycle during REQ-032 after beat 1 -> beat 2 never emitted; all outputs 0; next frame processes normally.

Source files
------------

// File: rtl/rle_expander.sv
// Run-length expander: unpacks (count, value) pairs from 512-bit AXI-Stream beats
// into 512-bit beats of VAL_W-bit lanes, carrying partial output beats across inputs.
module rle_expander #(
  parameter int PAIRS = 8,
  parameter int VAL_W = 32,
  parameter int CNT_W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [31:0]  frames_done
);
  localparam int LANES      = 512 / VAL_W;
  localparam int PAIR_W     = VAL_W + CNT_W;
  localparam int PAIR_BYTES = PAIR_W / 8;
  localparam int LANE_BYTES = VAL_W / 8;
  localparam int IDX_W      = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int FILL_W     = $clog2(LANES) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_EMIT = 2'd2} state_t;

  state_t              r_state, w_state;
  logic [511:0]        r_beat_data, w_beat_data;
  logic [63:0]         r_beat_keep, w_beat_keep;
  logic                r_beat_last, w_beat_last;
  logic                r_beat_done, w_beat_done;
  logic                r_pend_marker, w_pend_marker;
  logic [IDX_W-1:0]    r_pair_idx, w_pair_idx;
  logic [CNT_W-1:0]    r_rem, w_rem;
  logic [FILL_W-1:0]   r_fill, w_fill;
  logic [511:0]        r_lanes, w_lanes;
  logic                r_tready, w_tready;
  logic                r_m_tvalid, w_m_tvalid;
  logic                r_m_tlast, w_m_tlast;
  logic [63:0]         r_m_tkeep, w_m_tkeep;
  logic [511:0]        r_m_tdata, w_m_tdata;
  logic [31:0]         r_frames, w_frames;

  logic [PAIR_W-1:0]   w_pair;
  logic [VAL_W-1:0]    w_val;
  logic                w_pvalid;
  logic [IDX_W-1:0]    w_next_idx;
  logic [PAIR_W-1:0]   w_next_pair;
  logic [FILL_W-1:0]   w_space, w_n, w_fill_add;
  logic [CNT_W-1:0]    w_rem_sub;
  logic                w_pair_done, w_last_pair;
  logic [511:0]        w_lanes_wr;

  function automatic logic [63:0] fill_keep(input logic [FILL_W-1:0] f);
    logic [63:0] k;
    k = 64'd0;
    for (int j = 0; j < LANES; j++) begin
      if (FILL_W'(j) < f) k[j*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{1'b1}};
      else                k[j*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{1'b0}};
    end
    return k;
  endfunction

  // Datapath for the current pair: lanes written this cycle and remaining count
  always_comb begin
    w_pair      = r_beat_data[int'(r_pair_idx)*PAIR_W +: PAIR_W];
    w_val       = w_pair[VAL_W-1:0];
    w_pvalid    = &r_beat_keep[int'(r_pair_idx)*PAIR_BYTES +: PAIR_BYTES];
    w_next_idx  = (r_pair_idx == IDX_W'(PAIRS-1)) ? {IDX_W{1'b0}} : r_pair_idx + IDX_W'(1);
    w_next_pair = r_beat_data[int'(w_next_idx)*PAIR_W +: PAIR_W];
    w_space     = FILL_W'(LANES) - r_fill;
    if (!w_pvalid)                        w_n = {FILL_W{1'b0}};
    else if (r_rem < CNT_W'(w_space))     w_n = FILL_W'(r_rem);
    else                                  w_n = w_space;
    w_fill_add  = r_fill + w_n;
    w_rem_sub   = r_rem - CNT_W'(w_n);
    w_pair_done = !w_pvalid || (w_rem_sub == {CNT_W{1'b0}});
    w_last_pair = w_pair_done && (!w_pvalid || (r_pair_idx == IDX_W'(PAIRS-1)));
    w_lanes_wr  = r_lanes;
    for (int j = 0; j < LANES; j++) begin
      if (w_pvalid && (FILL_W'(j) >= r_fill) && (FILL_W'(j) < w_fill_add))
        w_lanes_wr[j*VAL_W +: VAL_W] = w_val;
      else
        w_lanes_wr[j*VAL_W +: VAL_W] = r_lanes[j*VAL_W +: VAL_W];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state       = r_state;
    w_beat_data   = r_beat_data;
    w_beat_keep   = r_beat_keep;
    w_beat_last   = r_beat_last;
    w_beat_done   = r_beat_done;
    w_pend_marker = r_pend_marker;
    w_pair_idx    = r_pair_idx;
    w_rem         = r_rem;
    w_fill        = r_fill;
    w_lanes       = r_lanes;
    w_m_tvalid    = r_m_tvalid;
    w_m_tlast     = r_m_tlast;
    w_m_tkeep     = r_m_tkeep;
    w_m_tdata     = r_m_tdata;
    w_frames      = r_frames;
    case (r_state)
      S_IDLE: begin
        if (s_axis_tvalid && r_tready) begin
          w_beat_data = s_axis_tdata;
          w_beat_keep = s_axis_tkeep;
          w_beat_last = s_axis_tlast;
          w_beat_done = 1'b0;
          w_pair_idx  = {IDX_W{1'b0}};
          w_rem       = s_axis_tdata[PAIR_W-1:VAL_W];
          w_state     = S_EXPAND;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_EXPAND: begin
        w_lanes = w_lanes_wr;
        w_fill  = w_fill_add;
        w_rem   = w_rem_sub;
        if (w_last_pair) begin
          w_rem       = {CNT_W{1'b0}};
          w_beat_done = 1'b1;
        end else if (w_pair_done) begin
          w_pair_idx = w_next_idx;
          w_rem      = w_next_pair[PAIR_W-1:VAL_W];
        end else begin
          w_pair_idx = r_pair_idx;
        end
        // A full beat never carries tlast; a closing tlast goes out as a separate marker
        if (w_fill_add == FILL_W'(LANES)) begin
          w_state       = S_EMIT;
          w_m_tvalid    = 1'b1;
          w_m_tlast     = 1'b0;
          w_m_tkeep     = {64{1'b1}};
          w_m_tdata     = w_lanes_wr;
          w_pend_marker = w_last_pair && r_beat_last;
        end else if (w_last_pair) begin
          if (r_beat_last) begin
            w_state    = S_EMIT;
            w_m_tvalid = 1'b1;
            w_m_tlast  = 1'b1;
            w_m_tkeep  = fill_keep(w_fill_add);
            w_m_tdata  = w_lanes_wr;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_state = S_EXPAND;
        end
      end
      S_EMIT: begin
        if (m_axis_tready) begin
          w_fill  = {FILL_W{1'b0}};
          w_lanes = 512'd0;
          if (r_m_tlast) w_frames = r_frames + 32'd1;
          else           w_frames = r_frames;
          if (r_pend_marker) begin
            w_pend_marker = 1'b0;
            w_m_tvalid    = 1'b1;
            w_m_tlast     = 1'b1;
            w_m_tkeep     = 64'd0;
            w_m_tdata     = 512'd0;
            w_state       = S_EMIT;
          end else begin
            w_m_tvalid = 1'b0;
            w_m_tlast  = 1'b0;
            w_m_tkeep  = 64'd0;
            w_m_tdata  = 512'd0;
            w_state    = r_beat_done ? S_IDLE : S_EXPAND;
          end
        end else begin
          w_state = S_EMIT;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_tready = (w_state == S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_beat_data   <= 512'd0;
      r_beat_keep   <= 64'd0;
      r_beat_last   <= 1'b0;
      r_beat_done   <= 1'b0;
      r_pend_marker <= 1'b0;
      r_pair_idx    <= {IDX_W{1'b0}};
      r_rem         <= {CNT_W{1'b0}};
      r_fill        <= {FILL_W{1'b0}};
      r_lanes       <= 512'd0;
      r_tready      <= 1'b0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_m_tkeep     <= 64'd0;
      r_m_tdata     <= 512'd0;
      r_frames      <= 32'd0;
    end else begin
      r_state       <= w_state;
      r_beat_data   <= w_beat_data;
      r_beat_keep   <= w_beat_keep;
      r_beat_last   <= w_beat_last;
      r_beat_done   <= w_beat_done;
      r_pend_marker <= w_pend_marker;
      r_pair_idx    <= w_pair_idx;
      r_rem         <= w_rem;
      r_fill        <= w_fill;
      r_lanes       <= w_lanes;
      r_tready      <= w_tready;
      r_m_tvalid    <= w_m_tvalid;
      r_m_tlast     <= w_m_tlast;
      r_m_tkeep     <= w_m_tkeep;
      r_m_tdata     <= w_m_tdata;
      r_frames      <= w_frames;
    end
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tdata  = r_m_tdata;
  assign frames_done   = r_frames;

endmodule
